vco_sample_fifo: RTL and testbench
==================================

# vco_sample_fifo

Output buffer that sits directly downstream of `vco_adc`. It captures every decimated sample presented with `data_valid_out` and holds it in a circular FIFO. A host-side consumer drains the samples with a simple read strobe. The block adds a programmable level threshold interrupt and a sticky overflow flag, so firmware can poll or service bursts without losing track of dropped samples.

## Interface
- `DATA_WIDTH`, default 32: sample width; matches `vco_adc` `data_out`.
- `DEPTH`, default 16: number of entries; must be a power of two, ≥ 2.
- `ADDR_WIDTH`, default 4: log2(`DEPTH`); pointer width.

Reset is asynchronous and active-high. One clock domain.

- `clk`, in, 1: sole clock; all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `data_in`, in, `DATA_WIDTH`: sample from `vco_adc` `data_out`.
- `data_valid_in`, in, 1: one-cycle write strobe from `vco_adc` `data_valid_out`.
- `clear_in`, in, 1: synchronous flush of contents and flags.
- `rd_en_in`, in, 1: read strobe; pops one entry if not empty.
- `threshold_in`, in, `ADDR_WIDTH`+1: interrupt level; 0 disables the interrupt.
- `data_out`, out, `DATA_WIDTH`: registered read data.
- `rd_valid_out`, out, 1: `data_out` holds a freshly popped sample.
- `level_out`, out, `ADDR_WIDTH`+1: current occupancy, 0..`DEPTH`.
- `empty_out`, out, 1: `level_out` == 0.
- `full_out`, out, 1: `level_out` == `DEPTH`.
- `overflow_out`, out, 1: sticky flag; at least one write was dropped.
- `irq_out`, out, 1: `threshold_in` != 0 and `level_out` ≥ `threshold_in`.

## Operation
- Storage is a `DEPTH`×`DATA_WIDTH` register array with write pointer `wp` and read pointer `rp`, each `ADDR_WIDTH` bits wide.
  - Pointers wrap modulo `DEPTH` by natural overflow.
  - A separate `level` counter tracks occupancy; `empty_out` and `full_out` derive from it.
- Write accepted = `data_valid_in` & (!`full` | read accepted).
  - On accept: `mem[wp]` ← `data_in`, `wp` increments.
- Write dropped = `data_valid_in` & `full` & !read accepted.
  - On drop: `overflow_out` ← 1; contents and pointers are unchanged.
- Read accepted = `rd_en_in` & !`empty`.
  - On accept: `data_out` ← `mem[rp]`, `rp` increments, `rd_valid_out` ← 1 for one cycle.
- `rd_en_in` while empty is ignored: `data_out` holds, `rd_valid_out` = 0.
- `level` update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on simultaneous write and read, or when neither occurs.
- Simultaneous write and read when full: both are accepted, level stays at `DEPTH`, no overflow.
- Simultaneous write and read when empty: only the write is accepted; level becomes 1; the read is ignored.
- `clear_in` has top priority over same-cycle writes and reads:
  - `wp`, `rp` and `level` go to 0; `overflow_out` and `rd_valid_out` go to 0.
  - `data_out` holds its value; memory contents are not cleared.
- `irq_out` is combinational from the `level` register and `threshold_in`.
  - Threshold values greater than `DEPTH` never fire.
- `level` arithmetic is `ADDR_WIDTH`+1 bits and never exceeds `DEPTH` or goes below 0.

## Timing
- Reset values: `data_out` = 0, `rd_valid_out` = 0, `level_out` = 0, `empty_out` = 1, `full_out` = 0, `overflow_out` = 0, `irq_out` = 0.
  - Pointers reset to 0; the memory array is not reset.
- Asserting `rst` mid-stream clears all state immediately, without waiting for a clock edge.
  - Samples arriving while `rst` is high are discarded.
- Write latency: a sample strobed at edge N is visible in `level_out` after edge N.
  - It is poppable by `rd_en_in` sampled at edge N+1.
- Read latency: `rd_en_in` sampled high at edge N gives `data_out` and `rd_valid_out` valid after edge N.
  - They are valid for exactly one cycle at `rd_valid_out`; `data_out` then holds until the next pop.
- Back-to-back reads every cycle sustain one sample per clock.
- `vco_adc` produces one sample per `oversample_in`+1 clocks, so steady-state draining never overflows.
- Flags (`empty_out`, `full_out`, `irq_out`) reflect the registered `level` and update the cycle after the causing edge.

## Test plan
- Reset and fill:
  - Stimulus: assert `rst` for 50 cycles, release, then write 16 samples 0x1..0x10 on alternate cycles.
  - Required: after reset, `empty_out` = 1 and all outputs at reset values; after the writes, `full_out` = 1, `level_out` = 16, `overflow_out` = 0.
- Ordered drain:
  - Stimulus: from full, hold `rd_en_in` for 17 cycles.
  - Required: `data_out` = 0x1..0x10 in order on 16 consecutive `rd_valid_out` pulses; the 17th read is ignored; `empty_out` = 1.
- Overflow:
  - Stimulus: fill to 16, write 0xDEAD.
  - Required: `overflow_out` = 1 and stays 1; `level_out` = 16; the next pop returns 0x1, not 0xDEAD.
  - Then assert `clear_in`: `overflow_out` = 0, `level_out` = 0.
- Simultaneous events:
  - Stimulus: at full, write 0xAA with `rd_en_in`.
  - Required: pop returns the oldest entry, `level_out` stays 16, no overflow.
  - Stimulus: at empty, write plus read together.
  - Required: `level_out` = 1, `rd_valid_out` = 0.
- Threshold and wrap:
  - Stimulus: `threshold_in` = 4; run 40 writes and reads interleaved to wrap the pointers twice.
  - Required: `irq_out` rises the cycle `level_out` reaches 4 and falls the cycle it drops to 3; data order is preserved across the wrap.
  - Stimulus: `threshold_in` = 0.
  - Required: `irq_out` stays 0.
- Live ADC:
  - Stimulus: connect `vco` → `vco_adc` (`oversample_in` = 0xff) → this block; drain whenever `irq_out` = 1 (`threshold_in` = 8); run 40000 clocks, including a `rst` pulse mid-run.
  - Required: no overflow; every `vco_adc` sample appears exactly once at `data_out`, in order; all state is 0 immediately on `rst`.

Source files
------------

// File: rtl/vco_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vco_sample_fifo
// Brief    : Circular sample FIFO behind vco_adc with level IRQ and sticky
//            overflow flag.
// Revision : 1.0
// ============================================================================
module vco_sample_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  input  logic                  clear_in,
  input  logic                  rd_en_in,
  input  logic [ADDR_WIDTH:0]   threshold_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid_out,
  output logic [ADDR_WIDTH:0]   level_out,
  output logic                  empty_out,
  output logic                  full_out,
  output logic                  overflow_out,
  output logic                  irq_out
);

  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_ONE   = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wp;
  logic [ADDR_WIDTH-1:0] r_rp;
  logic [ADDR_WIDTH:0]   r_level;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_rd_valid;
  logic                  r_overflow;

  logic w_empty;
  logic w_full;
  logic w_rd;
  logic w_wr;
  logic w_drop;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_DEPTH);
  assign w_rd    = rd_en_in & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr    = data_valid_in & (~w_full | w_rd);
  assign w_drop  = data_valid_in & w_full & ~w_rd;

  // Storage is deliberately left out of reset; pointers alone define contents.
  always_ff @(posedge clk) begin
    if (w_wr && !clear_in) begin
      r_mem[r_wp] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_level    <= '0;
      r_data     <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clear_in) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_level    <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_data <= r_mem[r_rp];
        r_rp   <= r_rp + 1'b1;
      end
      if (w_wr) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_wr && !w_rd) begin
        r_level <= r_level + c_ONE;
      end else if (w_rd && !w_wr) begin
        r_level <= r_level - c_ONE;
      end
    end
  end

  assign data_out     = r_data;
  assign rd_valid_out = r_rd_valid;
  assign level_out    = r_level;
  assign empty_out    = w_empty;
  assign full_out     = w_full;
  assign overflow_out = r_overflow;
  assign irq_out      = (threshold_in != '0) && (r_level >= threshold_in);

endmodule
`default_nettype wire

// File: tb/tb_vco_sample_fifo.sv
`default_nettype none
// Testbench for vco_sample_fifo: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_vco_sample_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_valid_in = 1'b0;
  logic          clear_in = 1'b0;
  logic          rd_en_in = 1'b0;
  logic [AW:0]   threshold_in = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid_out;
  logic [AW:0]   level_out;
  logic          empty_out;
  logic          full_out;
  logic          overflow_out;
  logic          irq_out;

  vco_sample_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_valid_in(data_valid_in),
    .clear_in     (clear_in),
    .rd_en_in     (rd_en_in),
    .threshold_in (threshold_in),
    .data_out     (data_out),
    .rd_valid_out (rd_valid_out),
    .level_out    (level_out),
    .empty_out    (empty_out),
    .full_out     (full_out),
    .overflow_out (overflow_out),
    .irq_out      (irq_out)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: queue contents plus the visible read-side registers.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_data = '0;
  logic          m_rv = 1'b0;
  logic          m_ovf = 1'b0;
  logic [DW-1:0] popped[$];

  always @(negedge clk) begin
    bit rd;
    bit wr;
    if (rst) begin
      m_q.delete();
      m_data = '0;
      m_rv = 1'b0;
      m_ovf = 1'b0;
    end
    check("data_out", 64'(data_out), 64'(m_data));
    check("rd_valid", 64'(rd_valid_out), 64'(m_rv));
    check("level", 64'(level_out), 64'(m_q.size()));
    check("empty", 64'(empty_out), 64'(m_q.size() == 0));
    check("full", 64'(full_out), 64'(m_q.size() == DEPTH));
    check("overflow", 64'(overflow_out), 64'(m_ovf));
    check("irq", 64'(irq_out), 64'((threshold_in != 0) && (m_q.size() >= int'(threshold_in))));
    if (rd_valid_out) popped.push_back(data_out);
    // Next state from the inputs that the coming rising edge will sample.
    if (rst) begin
      m_q.delete();
      m_rv = 1'b0;
    end else if (clear_in) begin
      m_q.delete();
      m_rv = 1'b0;
      m_ovf = 1'b0;
    end else begin
      rd = rd_en_in && (m_q.size() > 0);
      wr = data_valid_in && ((m_q.size() < DEPTH) || rd);
      m_rv = rd;
      if (rd) m_data = m_q.pop_front();
      if (wr) m_q.push_back(data_in);
      if (data_valid_in && !wr) m_ovf = 1'b1;
    end
  end

  // Inputs are applied 1 time unit after a rising edge and held for one cycle.
  task automatic cyc(input bit dv, input logic [DW-1:0] d, input bit rd, input bit clr);
    data_valid_in = dv;
    data_in = d;
    rd_en_in = rd;
    clear_in = clr;
    @(posedge clk);
    #1;
    data_valid_in = 1'b0;
    rd_en_in = 1'b0;
    clear_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, base + DW'(i), 1'b0, 1'b0);
  endtask

  initial begin
    repeat (50) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_data", 64'(data_out), 64'h0);
    check("rst_empty", 64'(empty_out), 64'h1);
    check("rst_level", 64'(level_out), 64'h0);
    check("rst_irq", 64'(irq_out), 64'h0);

    // Reset and fill on alternate cycles.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      idle(1);
    end
    check("fill_full", 64'(full_out), 64'h1);
    check("fill_level", 64'(level_out), 64'd16);
    check("fill_ovf", 64'(overflow_out), 64'h0);

    // Ordered drain with one extra ignored read.
    popped.delete();
    repeat (17) cyc(1'b0, '0, 1'b1, 1'b0);
    idle(2);
    check("drain_count", 64'(popped.size()), 64'd16);
    for (int i = 0; i < 16 && i < popped.size(); i++) check("drain_data", 64'(popped[i]), 64'(i + 1));
    check("drain_empty", 64'(empty_out), 64'h1);

    // Overflow, stickiness, oldest-first pop, then clear.
    fill('0);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
    check("ovf_set", 64'(overflow_out), 64'h1);
    check("ovf_level", 64'(level_out), 64'd16);
    idle(3);
    check("ovf_sticky", 64'(overflow_out), 64'h1);
    popped.delete();
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(1);
    check("ovf_pop", 64'(popped.size() > 0 ? popped[0] : 32'hFFFF_FFFF), 64'h1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("clr_ovf", 64'(overflow_out), 64'h0);
    check("clr_level", 64'(level_out), 64'h0);

    // Simultaneous write and read at full, then at empty.
    fill(32'h100);
    popped.delete();
    cyc(1'b1, 32'hAA, 1'b1, 1'b0);
    check("sim_full_level", 64'(level_out), 64'd16);
    check("sim_full_ovf", 64'(overflow_out), 64'h0);
    idle(1);
    check("sim_full_pop", 64'(popped.size() > 0 ? popped[0] : 32'hFFFF_FFFF), 64'h101);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b1, 32'h55, 1'b1, 1'b0);
    check("sim_empty_level", 64'(level_out), 64'd1);
    check("sim_empty_rv", 64'(rd_valid_out), 64'h0);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Threshold edges and pointer wrap.
    threshold_in = 5'd4;
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 32'h300 + DW'(i), 1'b0, 1'b0);
      check("thr_irq", 64'(irq_out), 64'(i == 4));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("thr_fall_level", 64'(level_out), 64'd3);
    check("thr_fall_irq", 64'(irq_out), 64'h0);
    idle(1);
    popped.delete();
    for (int i = 0; i < 40; i++) cyc(1'b1, 32'h200 + DW'(i), 1'b1, 1'b0);
    idle(1);
    check("wrap_count", 64'(popped.size()), 64'd40);
    if (popped.size() == 40) begin
      check("wrap_first", 64'(popped[0]), 64'h302);
      check("wrap_cross", 64'(popped[3]), 64'h200);
      check("wrap_last", 64'(popped[39]), 64'h224);
    end
    threshold_in = 5'd0;
    fill(32'h400);
    check("thr0_irq", 64'(irq_out), 64'h0);
    threshold_in = 5'd17;
    idle(1);
    check("thr17_irq", 64'(irq_out), 64'h0);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Paced producer with irq-driven draining and an asynchronous reset pulse.
    threshold_in = 5'd8;
    for (int i = 0; i < 800; i++) begin
      data_valid_in = (i % 4 == 0);
      data_in = 32'h1000 + DW'(i);
      rd_en_in = irq_out;
      if (i == 400) begin
        rst = 1'b1;
        #1;
        check("arst_level", 64'(level_out), 64'h0);
        check("arst_data", 64'(data_out), 64'h0);
        check("arst_rv", 64'(rd_valid_out), 64'h0);
        check("arst_empty", 64'(empty_out), 64'h1);
      end
      if (i == 404) rst = 1'b0;
      @(posedge clk);
      #1;
    end
    data_valid_in = 1'b0;
    rd_en_in = 1'b0;
    idle(2);
    check("live_ovf", 64'(overflow_out), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
